// File: rtl/jtag_tap_ctrl_ice1f.sv
// rtl/jtag_tap_ctrl_ice1f.sv - IEEE 1149.1 TAP controller with IDCODE, bypass and boundary-chain control
// Shift registers move on the rising tclk edge taken while in a Shift state; totdopad is the bit shifted out.
module jtag_tap_ctrl_ice1f #(
  parameter logic [31:0] IDCODE = 32'h0000_1043,
  parameter int          IR_W   = 4
) (
  input  logic tclk,
  input  logic r,
  input  logic tms,
  input  logic tdi,
  input  logic sdo,
  output logic sdi,
  output logic shift,
  output logic update,
  output logic bs_en,
  output logic hiz_b,
  output logic mode,
  output logic mux_jtag_sel_b,
  output logic totdopad,
  output logic sdo_enable
);

  localparam logic [IR_W-1:0] I_EXTEST  = IR_W'(4'b0000);
  localparam logic [IR_W-1:0] I_SAMPLE  = IR_W'(4'b0001);
  localparam logic [IR_W-1:0] I_IDCODE  = IR_W'(4'b0010);
  localparam logic [IR_W-1:0] I_HIGHZ   = IR_W'(4'b0011);
  localparam logic [IR_W-1:0] I_CAPTURE = IR_W'(4'b0001);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  tap_state_t      state, next_state;
  logic [IR_W-1:0] ir, ir_sr;
  logic [31:0]     idcode_sr;
  logic            bypass;
  logic            sel_chain, sel_idcode;
  logic            new_bs_en, new_hiz_b, new_mode;

  assign sdi = tdi;

  always_comb begin
    next_state = state;
    case (state)
      TLR:    next_state = tms ? TLR    : RTI;
      RTI:    next_state = tms ? SEL_DR : RTI;
      SEL_DR: next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR: next_state = tms ? EX1_DR : SH_DR;
      SH_DR:  next_state = tms ? EX1_DR : SH_DR;
      EX1_DR: next_state = tms ? UPD_DR : PAU_DR;
      PAU_DR: next_state = tms ? EX2_DR : PAU_DR;
      EX2_DR: next_state = tms ? UPD_DR : SH_DR;
      UPD_DR: next_state = tms ? SEL_DR : RTI;
      SEL_IR: next_state = tms ? TLR    : CAP_IR;
      CAP_IR: next_state = tms ? EX1_IR : SH_IR;
      SH_IR:  next_state = tms ? EX1_IR : SH_IR;
      EX1_IR: next_state = tms ? UPD_IR : PAU_IR;
      PAU_IR: next_state = tms ? EX2_IR : PAU_IR;
      EX2_IR: next_state = tms ? UPD_IR : SH_IR;
      UPD_IR: next_state = tms ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  // Unlisted instruction codes fall through to the bypass register.
  always_comb begin
    sel_chain  = (ir == I_EXTEST) || (ir == I_SAMPLE);
    sel_idcode = (ir == I_IDCODE);
    new_bs_en  = (ir_sr == I_EXTEST) || (ir_sr == I_HIGHZ);
    new_hiz_b  = (ir_sr != I_HIGHZ);
    new_mode   = (ir_sr == I_EXTEST);
  end

  assign shift  = (state == SH_DR)  && sel_chain;
  assign update = (state == UPD_DR) && sel_chain;

  always_ff @(posedge tclk) begin
    if (r) begin
      state          <= TLR;
      ir             <= I_IDCODE;
      ir_sr          <= I_CAPTURE;
      idcode_sr      <= IDCODE;
      bypass         <= 1'b0;
      totdopad       <= 1'b0;
      sdo_enable     <= 1'b0;
      bs_en          <= 1'b0;
      hiz_b          <= 1'b1;
      mode           <= 1'b0;
      mux_jtag_sel_b <= 1'b1;
    end else begin
      state      <= next_state;
      sdo_enable <= (next_state == SH_DR) || (next_state == SH_IR);
      case (state)
        CAP_IR: ir_sr <= I_CAPTURE;
        SH_IR: begin
          totdopad <= ir_sr[0];
          ir_sr    <= {tdi, ir_sr[IR_W-1:1]};
        end
        CAP_DR: begin
          if (sel_idcode)      idcode_sr <= IDCODE;
          else if (!sel_chain) bypass    <= 1'b0;
        end
        SH_DR: begin
          if (sel_idcode) begin
            totdopad  <= idcode_sr[0];
            idcode_sr <= {tdi, idcode_sr[31:1]};
          end else if (sel_chain) begin
            totdopad <= sdo;
          end else begin
            totdopad <= bypass;
            bypass   <= tdi;
          end
        end
        default: ;
      endcase
      // Pad-control outputs only move together with IR.
      if (state == UPD_IR) begin
        ir             <= ir_sr;
        bs_en          <= new_bs_en;
        hiz_b          <= new_hiz_b;
        mode           <= new_mode;
        mux_jtag_sel_b <= !new_bs_en;
      end else if (next_state == TLR) begin
        ir             <= I_IDCODE;
        bs_en          <= 1'b0;
        hiz_b          <= 1'b1;
        mode           <= 1'b0;
        mux_jtag_sel_b <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl_ice1f.sv
// tb/tb_jtag_tap_ctrl_ice1f.sv - self-checking bench for jtag_tap_ctrl_ice1f
// A queue-based TAP model predicts every output after every tclk edge.
module tb_jtag_tap_ctrl_ice1f;
  localparam logic [31:0] IDC = 32'h0000_1043;
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PAUDR = 6, EX2DR = 7,
                 UPDDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPDIR = 15;

  int nxt0 [16] = '{RTI, RTI, CAPDR, SHDR, SHDR, PAUDR, PAUDR, SHDR, RTI, CAPIR, SHIR, SHIR, PAUIR, PAUIR, SHIR, RTI};
  int nxt1 [16] = '{TLR, SELDR, SELIR, EX1DR, EX1DR, UPDDR, EX2DR, UPDDR, SELDR, TLR, EX1IR, EX1IR, UPDIR, EX2IR, UPDIR, SELDR};

  logic tclk = 1'b0;
  logic r = 1'b1, tms = 1'b0, tdi = 1'b0, sdo = 1'b0;
  logic sdi, shift, update, bs_en, hiz_b, mode, mux_jtag_sel_b, totdopad, sdo_enable;

  int n_assert = 0, n_fail = 0;
  int cnt_oe, cnt_sh, cnt_up;

  int         m_st;
  logic [3:0] m_ir;
  bit         ir_q[$];
  bit         dr_q[$];
  logic       m_tdo, m_oe;

  jtag_tap_ctrl_ice1f dut (
    .tclk(tclk), .r(r), .tms(tms), .tdi(tdi), .sdo(sdo), .sdi(sdi), .shift(shift), .update(update),
    .bs_en(bs_en), .hiz_b(hiz_b), .mode(mode), .mux_jtag_sel_b(mux_jtag_sel_b),
    .totdopad(totdopad), .sdo_enable(sdo_enable)
  );

  always #5 tclk = ~tclk;

  // 0: boundary chain, 1: IDCODE register, 2: one-bit bypass
  function automatic int kind(input logic [3:0] c);
    if (c == 4'd0 || c == 4'd1) return 0;
    if (c == 4'd2) return 1;
    return 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rr, input logic t, input logic d, input logic s);
    int ns;
    logic [31:0] idv;
    idv = IDC;
    if (rr) begin
      m_st = TLR; m_ir = 4'd2; m_tdo = 1'b0; m_oe = 1'b0;
      ir_q = {}; ir_q.push_back(1'b1); ir_q.push_back(1'b0); ir_q.push_back(1'b0); ir_q.push_back(1'b0);
      dr_q = {};
      return;
    end
    ns = t ? nxt1[m_st] : nxt0[m_st];
    case (m_st)
      CAPIR: begin
        ir_q = {}; ir_q.push_back(1'b1); ir_q.push_back(1'b0); ir_q.push_back(1'b0); ir_q.push_back(1'b0);
      end
      SHIR: begin
        m_tdo = ir_q.pop_front();
        ir_q.push_back(d);
      end
      CAPDR: begin
        dr_q = {};
        if (kind(m_ir) == 1) for (int i = 0; i < 32; i++) dr_q.push_back(idv[i]);
        else if (kind(m_ir) == 2) dr_q.push_back(1'b0);
      end
      SHDR: begin
        if (dr_q.size() == 0) m_tdo = s;
        else begin
          m_tdo = dr_q.pop_front();
          dr_q.push_back(d);
        end
      end
      UPDIR: for (int i = 0; i < 4; i++) m_ir[i] = ir_q[i];
      default: ;
    endcase
    if (ns == TLR) m_ir = 4'd2;
    m_oe = (ns == SHDR) || (ns == SHIR);
    m_st = ns;
  endtask

  task automatic check_outputs();
    logic en;
    en = (m_ir == 4'd0) || (m_ir == 4'd3);
    chk("sdi", sdi, tdi);
    chk("totdopad", totdopad, m_tdo);
    chk("sdo_enable", sdo_enable, m_oe);
    chk("shift", shift, (m_st == SHDR) && kind(m_ir) == 0);
    chk("update", update, (m_st == UPDDR) && kind(m_ir) == 0);
    chk("bs_en", bs_en, en);
    chk("hiz_b", hiz_b, m_ir != 4'd3);
    chk("mode", mode, m_ir == 4'd0);
    chk("mux_jtag_sel_b", mux_jtag_sel_b, !en);
  endtask

  task automatic clk_edge(input logic rr, input logic t, input logic d);
    logic s;
    s = 1'($urandom);
    r = rr; tms = t; tdi = d; sdo = s;
    @(posedge tclk);
    model_step(rr, t, d, s);
    #1;
    check_outputs();
    cnt_oe += int'(sdo_enable);
    cnt_sh += int'(shift);
    cnt_up += int'(update);
  endtask

  task automatic load_ir(input logic [3:0] code);
    clk_edge(0, 1, 0); clk_edge(0, 1, 0); clk_edge(0, 0, 0); clk_edge(0, 0, 0);
    for (int i = 0; i < 4; i++) clk_edge(0, i == 3, code[i]);
    clk_edge(0, 1, 0); clk_edge(0, 0, 0);
  endtask

  task automatic shift_dr(input int n, input logic [31:0] d, output logic [31:0] bits);
    bits = '0; cnt_oe = 0; cnt_sh = 0; cnt_up = 0;
    clk_edge(0, 1, 0); clk_edge(0, 0, 0); clk_edge(0, 0, 0);
    for (int i = 0; i < n; i++) begin
      clk_edge(0, i == n - 1, d[i]);
      bits[i] = totdopad;
    end
    clk_edge(0, 1, 0); clk_edge(0, 0, 0);
  endtask

  initial begin
    logic [31:0] bits, d;
    logic [3:0]  code;
    cnt_oe = 0; cnt_sh = 0; cnt_up = 0;

    clk_edge(1, 1, 0);
    chk("rst_bs_en", bs_en, 0); chk("rst_hiz_b", hiz_b, 1); chk("rst_mux", mux_jtag_sel_b, 1);
    chk("rst_totdopad", totdopad, 0); chk("rst_sdo_enable", sdo_enable, 0);
    clk_edge(0, 0, 0);
    chk("rti_shift", shift, 0); chk("rti_mode", mode, 0);

    shift_dr(32, 32'h0, bits);
    chk("idcode_seq", bits, IDC);
    chk("idcode_oe_cycles", cnt_oe, 32);

    load_ir(4'b0000);
    chk("extest_bs_en", bs_en, 1); chk("extest_mode", mode, 1);
    chk("extest_hiz_b", hiz_b, 1); chk("extest_mux", mux_jtag_sel_b, 0);
    shift_dr(8, 32'h5A, bits);
    chk("extest_shift_cycles", cnt_sh, 8);
    chk("extest_update_pulses", cnt_up, 1);

    load_ir(4'b0011);
    chk("highz_hiz_b", hiz_b, 0); chk("highz_bs_en", bs_en, 1);
    shift_dr(3, 32'b101, bits);
    chk("highz_bypass_seq", bits[2:0], 3'b010);

    load_ir(4'b1010);
    d = 32'h16;
    shift_dr(5, d, bits);
    chk("undef_bypass_seq", bits[4:0], (d << 1) & 32'h1F);
    chk("undef_no_shift", cnt_sh, 0);

    load_ir(4'b0010);
    clk_edge(0, 1, 0); clk_edge(0, 0, 0); clk_edge(0, 0, 0);
    for (int i = 0; i < 4; i++) clk_edge(0, i == 3, 0);
    clk_edge(0, 0, 0); clk_edge(0, 0, 0); clk_edge(0, 1, 0); clk_edge(0, 0, 0);
    bits = '0;
    for (int i = 0; i < 4; i++) begin
      clk_edge(0, i == 3, 0);
      bits[i] = totdopad;
    end
    chk("pause_resume_nibble", bits[3:0], 4'h4);
    clk_edge(0, 1, 0); clk_edge(0, 0, 0);

    load_ir(4'b0000);
    clk_edge(0, 1, 0); clk_edge(0, 0, 0); clk_edge(0, 0, 0); clk_edge(0, 0, 1);
    clk_edge(0, 1, 0); clk_edge(0, 0, 0);
    for (int i = 0; i < 5; i++) clk_edge(0, 1, 0);
    chk("tlr_bs_en", bs_en, 0); chk("tlr_mode", mode, 0);
    clk_edge(0, 0, 0);
    shift_dr(8, 32'h0, bits);
    chk("tlr_ir_idcode", bits[7:0], 8'h43);

    clk_edge(0, 1, 0); clk_edge(0, 1, 0); clk_edge(0, 0, 0); clk_edge(0, 0, 0);
    clk_edge(0, 0, 0); clk_edge(0, 0, 0);
    clk_edge(1, 1, 0);
    chk("midir_rst_bs_en", bs_en, 0); chk("midir_rst_oe", sdo_enable, 0);
    clk_edge(0, 0, 0);
    shift_dr(8, 32'h0, bits);
    chk("midir_ir_kept", bits[7:0], 8'h43);

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 5))
        0: code = 4'b0000; 1: code = 4'b0001; 2: code = 4'b0010;
        3: code = 4'b0011; 4: code = 4'b1111; default: code = 4'($urandom);
      endcase
      load_ir(code);
      shift_dr($urandom_range(1, 32), $urandom, bits);
    end

    for (int k = 0; k < 3000; k++)
      clk_edge($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35, 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/jtag_tap_ctrl_ice1f.md
JTAG_TAP_CTRL_ICE1F -- requirements
Module: jtag_tap_ctrl_ice1f

Interface
REQ-001 Parameter: IDCODE, default 32'h0000_1043, device ID captured in Capture-DR under IDCODE; bit 0 SHALL be 1.
REQ-002 Parameter: IR_W, default 4, instruction register width.
REQ-003 tclk  input  1  sole clock; all state changes on rising edge.
REQ-004 r  input  1  reset, synchronous, active-high.
REQ-005 tms  input  1  test mode select, from tms_pad buffer.
REQ-006 tdi  input  1  test data in, from tdi_pad buffer.
REQ-007 sdo  input  1  serial out of the last IO-column boundary-scan cell.
REQ-008 sdi  output  1  serial in to the first boundary-scan cell; combinational copy of tdi.
REQ-009 shift  output  1  boundary chain shift enable.
REQ-010 update  output  1  boundary chain update strobe, one cycle wide.
REQ-011 bs_en  output  1  boundary cells drive pads (EXTEST or HIGHZ active).
REQ-012 hiz_b  output  1  low forces all pads high-Z (HIGHZ active).
REQ-013 mode  output  1  1 = EXTEST, pads driven from update latches.
REQ-014 mux_jtag_sel_b  output  1  low while bs_en is high; gates JTAG-shared config bits.
REQ-015 totdopad  output  1  registered TDO.
REQ-016 sdo_enable  output  1  TDO pad output enable.

Function
REQ-017 TAP FSM SHALL implement the 16 IEEE 1149.1 states (TLR, RTI, Sel-DR, Cap-DR, Sh-DR, Ex1-DR, Pau-DR, Ex2-DR, Upd-DR, and the matching IR states) with standard tms transitions on each rising tclk edge.
REQ-018 Any state SHALL reach TLR after 5 consecutive tclk edges with tms=1.
REQ-019 In TLR, IR SHALL hold IDCODE (4'b0010).
REQ-020 Instruction decode: 4'b0000 EXTEST, 4'b0001 SAMPLE, 4'b0010 IDCODE, 4'b0011 HIGHZ, 4'b1111 BYPASS; any other code SHALL decode as BYPASS.
REQ-021 Cap-IR SHALL load the IR shift register with 4'b0001; Sh-IR SHALL shift right, tdi into MSB; Upd-IR SHALL copy the shift register into IR.
REQ-022 Cap-DR SHALL load: IDCODE -> IDCODE; BYPASS/HIGHZ -> 1-bit bypass register 0; EXTEST/SAMPLE -> no internal load (chain captures externally).
REQ-023 On each edge in Sh-IR or Sh-DR: totdopad <= LSB of the selected register (chain: sdo) and that register shifts in tdi in the same edge.
REQ-024 sdo_enable SHALL be 1 exactly in cycles after any edge that left the FSM in Sh-IR or Sh-DR, else 0; totdopad holds its last value when not shifting.
REQ-025 shift SHALL equal 1 while state = Sh-DR and IR in {EXTEST, SAMPLE}, else 0.
REQ-026 update SHALL pulse 1 for the single cycle state = Upd-DR and IR in {EXTEST, SAMPLE}.
REQ-027 bs_en = 1 iff IR in {EXTEST, HIGHZ}; hiz_b = 0 iff IR = HIGHZ; mode = 1 iff IR = EXTEST; mux_jtag_sel_b = not bs_en. All registered, changing only on the edge leaving Upd-IR or entering TLR.
REQ-028 Pause states SHALL hold all shift-register contents; Ex2 -> Sh resumes without recapture.

Reset
REQ-029 r=1 at a rising edge SHALL force: state TLR, IR 4'b0010, IR shift reg 4'b0001, bypass 0, totdopad 0, sdo_enable 0, shift 0, update 0, bs_en 0, hiz_b 1, mode 0, mux_jtag_sel_b 1.
REQ-030 r asserted mid-shift SHALL discard partial shift contents; IR unchanged from any in-flight Sh-IR.
REQ-031 r SHALL dominate tms on the same edge.

Verification
REQ-032 r pulse, then tms=0 -> RTI; IR=IDCODE; all outputs at REQ-029 values.
REQ-033 Load IDCODE, shift 32 DR bits with tdi=0 -> totdopad sequence equals IDCODE LSB-first (first bit 1), sdo_enable=1 for exactly 32 cycles.
REQ-034 Shift IR=4'b0000 (EXTEST), Upd-IR -> bs_en=1, mode=1, hiz_b=1, mux_jtag_sel_b=0; then 8 Sh-DR cycles -> shift=1 for 8 cycles, totdopad follows sdo one edge late, update single pulse in Upd-DR.
REQ-035 IR=4'b0011 (HIGHZ) -> hiz_b=0, bs_en=1; DR shift of tdi pattern 1,0,1 -> totdopad 0,1,0 (1-bit bypass delay).
REQ-036 IR=4'b1010 (undefined) -> behaves as BYPASS; shift never asserted.
REQ-037 tms=1 for 5 edges from Pau-DR under EXTEST -> TLR; bs_en=0, mode=0, IR=IDCODE; r asserted during Sh-IR mid-way -> IR remains prior value.
